operand_sequencer: RTL and testbench

Executes one operand-stack bytecode operation at a time (push, pop, arithmetic/logic, dup, swap) by sequencing push/pop accesses on the `stack` block's trigger/done handshake. It sits directly upstream of `stack`, between the bytecode decode stage and the operand stack, and owns depth tracking and underflow/overflow checking so that `stack` never sees an illegal access.

---
 rtl/operand_pkg.sv | 36 +++
 rtl/operand_alu.sv | 27 ++
 rtl/operand_sequencer.sv | 162 ++++++++++++++++
 tb/tb_operand_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_pkg.sv
// Shared types and per-opcode sequencing constants for the operand sequencer.
package operand_pkg;

  typedef enum logic [3:0] {
    OP_PUSH = 4'd0,
    OP_POP  = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_NEG  = 4'd7,
    OP_DUP  = 4'd8,
    OP_SWAP = 4'd9
  } op_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP1  = 3'd1,
    POP2  = 3'd2,
    PUSH1 = 3'd3,
    PUSH2 = 3'd4,
    DONE  = 3'd5
  } seq_state_t;

  localparam int NUM_OPS = 10;

  // Indexed by raw opcode; illegal opcodes carry zeros and are rejected separately.
  localparam int POPS_NEEDED [16] = '{0, 1, 2, 2, 2, 2, 2, 1, 1, 2, 0, 0, 0, 0, 0, 0};
  localparam int NET_GROWTH  [16] = '{1, -1, -1, -1, -1, -1, -1, 0, 1, 0, 0, 0, 0, 0, 0, 0};

  function automatic logic op_legal(input logic [3:0] code);
    return code < 4'(NUM_OPS);
  endfunction

endpackage

// File: rtl/operand_alu.sv
// Combinational ALU for the binary ops (B op A) and negation of A.
module operand_alu
  import operand_pkg::*;
#(
  parameter int STACKDATA = 32
) (
  input  op_t                  op,
  input  logic [STACKDATA-1:0] a,
  input  logic [STACKDATA-1:0] b,
  output logic [STACKDATA-1:0] y
);

  // Modulo-2^STACKDATA arithmetic; no flags.
  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = b + a;
      OP_SUB:  y = b - a;
      OP_AND:  y = b & a;
      OP_OR:   y = b | a;
      OP_XOR:  y = b ^ a;
      OP_NEG:  y = '0 - a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/operand_sequencer.sv
// Sequences one stack bytecode op as pop/push accesses on the stack handshake,
// tracking depth and rejecting ops that would under/overflow the stack.
module operand_sequencer
  import operand_pkg::*;
#(
  parameter int STACKDATA = 32,
  parameter int STACKSIZE = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               op_valid,
  input  logic [3:0]                         op_code,
  input  logic [STACKDATA-1:0]               op_operand,
  output logic                               op_ready,
  output logic [STACKDATA-1:0]               result,
  output logic                               result_valid,
  output logic                               error,
  output logic [$clog2(STACKSIZE+1)-1:0]     depth,
  output logic                               stk_push,
  output logic                               stk_trigger,
  output logic [STACKDATA-1:0]               stk_write_value,
  input  logic [STACKDATA-1:0]               stk_read_value,
  input  logic                               stk_done
);

  localparam int DW = $clog2(STACKSIZE+1);

  seq_state_t           state;
  seq_state_t           next_after;
  logic                 waiting;
  logic                 err_q;
  op_t                  op_q;
  logic [1:0]           pops_q;
  logic [1:0]           pushes_q;
  logic [STACKDATA-1:0] operand_q;
  logic [STACKDATA-1:0] a_q;
  logic [STACKDATA-1:0] b_q;
  logic [STACKDATA-1:0] alu_y;
  logic [STACKDATA-1:0] result_sel;
  logic                 in_pop;
  logic                 in_push;
  logic                 accept;
  logic                 reject;
  int                   pops_req;
  int                   growth_req;

  operand_alu #(.STACKDATA(STACKDATA)) u_alu (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (alu_y)
  );

  assign in_pop       = (state == POP1) || (state == POP2);
  assign in_push      = (state == PUSH1) || (state == PUSH2);
  assign op_ready     = (state == IDLE);
  assign accept       = op_valid && op_ready;
  assign stk_trigger  = (in_pop || in_push) && !waiting;
  assign stk_push     = in_push;
  assign result_valid = (state == DONE) && !err_q;
  assign error        = (state == DONE) && err_q;

  // Legality of the presented op against the current depth.
  always_comb begin
    pops_req   = POPS_NEEDED[op_code];
    growth_req = NET_GROWTH[op_code];
    reject     = !op_legal(op_code)
              || (pops_req > int'(depth))
              || (int'(depth) + growth_req > STACKSIZE);
  end

  // Successor of the current access state once its stk_done arrives.
  always_comb begin
    next_after = DONE;
    case (state)
      POP1:    if (pops_q == 2'd2) next_after = POP2;
               else if (pushes_q != 2'd0) next_after = PUSH1;
      POP2:    if (pushes_q != 2'd0) next_after = PUSH1;
      PUSH1:   if (pushes_q == 2'd2) next_after = PUSH2;
      default: next_after = DONE;
    endcase
  end

  // Value written by the current push access.
  always_comb begin
    stk_write_value = '0;
    if (state == PUSH1) begin
      case (op_q)
        OP_PUSH:          stk_write_value = operand_q;
        OP_DUP, OP_SWAP:  stk_write_value = a_q;
        default:          stk_write_value = alu_y;
      endcase
    end else if (state == PUSH2) begin
      stk_write_value = (op_q == OP_SWAP) ? b_q : a_q;
    end
  end

  // Result latched on the final access; a POP-only op completes on its own
  // read, before a_q is loaded, so it takes the read value directly.
  always_comb begin
    case (op_q)
      OP_PUSH: result_sel = operand_q;
      OP_POP:  result_sel = stk_read_value;
      OP_DUP:  result_sel = a_q;
      OP_SWAP: result_sel = b_q;
      default: result_sel = alu_y;
    endcase
  end

  // Sequencer state, operand capture, depth tracking and result register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      waiting   <= 1'b0;
      err_q     <= 1'b0;
      op_q      <= OP_PUSH;
      pops_q    <= '0;
      pushes_q  <= '0;
      operand_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result    <= '0;
      depth     <= '0;
    end else begin
      case (state)
        IDLE: begin
          waiting <= 1'b0;
          err_q   <= 1'b0;
          if (accept) begin
            op_q      <= op_t'(op_code);
            operand_q <= op_operand;
            pops_q    <= 2'(pops_req);
            pushes_q  <= 2'(pops_req + growth_req);
            if (reject) begin
              err_q <= 1'b1;
              state <= DONE;
            end else begin
              state <= (pops_req != 0) ? POP1 : PUSH1;
            end
          end
        end
        DONE: begin
          err_q <= 1'b0;
          state <= IDLE;
        end
        default: begin
          if (!waiting) begin
            waiting <= 1'b1;
          end else if (stk_done) begin
            waiting <= 1'b0;
            state   <= next_after;
            depth   <= in_push ? depth + DW'(1) : depth - DW'(1);
            if (state == POP1) a_q <= stk_read_value;
            if (state == POP2) b_q <= stk_read_value;
            if (next_after == DONE) result <= result_sel;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_sequencer.sv
`timescale 1ns/1ps
// Bench for operand_sequencer: behavioural stack responder with variable
// response delay, queue-based reference model, directed plus random ops.
module tb_operand_sequencer;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic [3:0]  op_code;
  logic [31:0] op_operand;
  logic        op_ready;
  logic [31:0] result;
  logic        result_valid;
  logic        error;
  logic [4:0]  depth;
  logic        stk_push;
  logic        stk_trigger;
  logic [31:0] stk_write_value;
  logic [31:0] stk_read_value;
  logic        stk_done;

  int n_checks = 0;
  int n_errors = 0;

  operand_sequencer #(.STACKDATA(32), .STACKSIZE(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .op_valid        (op_valid),
    .op_code         (op_code),
    .op_operand      (op_operand),
    .op_ready        (op_ready),
    .result          (result),
    .result_valid    (result_valid),
    .error           (error),
    .depth           (depth),
    .stk_push        (stk_push),
    .stk_trigger     (stk_trigger),
    .stk_write_value (stk_write_value),
    .stk_read_value  (stk_read_value),
    .stk_done        (stk_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stack: responds d_cfg cycles after each trigger (d_cfg >= 1).
  logic [31:0] smem [16];
  int          sp = 0;
  int          cnt = 0;
  int          trig_cnt = 0;
  int          d_cfg = 1;
  bit          busy = 0;
  bit          p_push = 0;
  logic [31:0] p_val = '0;

  task automatic stk_apply(input bit push, input logic [31:0] v);
    stk_done <= 1'b1;
    if (push) begin
      if (sp < 16) begin
        smem[sp] <= v;
        sp       <= sp + 1;
      end
    end else if (sp > 0) begin
      stk_read_value <= smem[sp-1];
      sp             <= sp - 1;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp             <= 0;
      busy           <= 0;
      cnt            <= 0;
      stk_done       <= 1'b0;
      stk_read_value <= '0;
    end else begin
      stk_done <= 1'b0;
      if (stk_trigger) begin
        trig_cnt <= trig_cnt + 1;
        if (d_cfg <= 1) begin
          stk_apply(stk_push, stk_write_value);
        end else begin
          busy   <= 1;
          cnt    <= d_cfg - 2;
          p_push <= stk_push;
          p_val  <= stk_write_value;
        end
      end else if (busy) begin
        if (cnt == 0) begin
          busy <= 0;
          stk_apply(p_push, p_val);
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  // Reference model: stack as a queue, top at the back.
  logic [31:0] ref_q[$];
  logic [31:0] hold_res = '0;

  task automatic model(input logic [3:0] code, input logic [31:0] v,
                       output bit e, output logic [31:0] r, output int k);
    logic [31:0] a;
    logic [31:0] b;
    int need;
    int grow;
    e = 0; r = hold_res; k = 0; need = 0; grow = 0;
    case (code)
      4'd0:                      begin need = 0; grow =  1; end
      4'd1:                      begin need = 1; grow = -1; end
      4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin need = 2; grow = -1; end
      4'd7:                      begin need = 1; grow =  0; end
      4'd8:                      begin need = 1; grow =  1; end
      4'd9:                      begin need = 2; grow =  0; end
      default:                   e = 1;
    endcase
    if (!e && (need > ref_q.size() || ref_q.size() + grow > 16)) e = 1;
    if (e) return;
    k = 2 * need + grow;
    case (code)
      4'd0: begin ref_q.push_back(v); r = v; end
      4'd1: r = ref_q.pop_back();
      4'd7: begin a = ref_q.pop_back(); r = 32'd0 - a; ref_q.push_back(r); end
      4'd8: begin a = ref_q[$]; r = a; ref_q.push_back(a); end
      4'd9: begin
        a = ref_q.pop_back(); b = ref_q.pop_back();
        ref_q.push_back(a); ref_q.push_back(b); r = b;
      end
      default: begin
        a = ref_q.pop_back(); b = ref_q.pop_back();
        case (code)
          4'd2:    r = b + a;
          4'd3:    r = b - a;
          4'd4:    r = b & a;
          4'd5:    r = b | a;
          default: r = b ^ a;
        endcase
        ref_q.push_back(r);
      end
    endcase
    hold_res = r;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, keep op_valid high with garbage while busy, check completion.
  task automatic do_op(input logic [3:0] code, input logic [31:0] v, input int d);
    bit          e;
    logic [31:0] r;
    int          k;
    int          base;
    int          lat;
    bit          seen;
    model(code, v, e, r, k);
    @(negedge clk);
    base  = trig_cnt;
    d_cfg = d;
    op_valid = 1'b1; op_code = code; op_operand = v;
    chk("op_ready_idle", op_ready, 1);
    @(negedge clk);
    op_code = 4'($urandom); op_operand = $urandom;
    lat = 1; seen = 0;
    while (!seen && lat <= 100) begin
      if (result_valid || error) seen = 1;
      else begin @(negedge clk); lat++; end
    end
    chk("completion_timeout", seen, 1);
    chk("error_flag", error, e);
    chk("result_valid", result_valid, !e);
    chk("op_ready_busy", op_ready, 0);
    chk("result", result, r);
    chk("depth", depth, ref_q.size());
    chk("latency", lat, e ? 1 : k * (d + 1) + 1);
    chk("trigger_count", trig_cnt - base, k);
    op_valid = 1'b0;
    @(negedge clk);
    chk("op_ready_after", op_ready, 1);
    chk("pulse_one_cycle", {result_valid, error}, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_op_ready"}, op_ready, 1);
    chk({tag, "_trigger"}, stk_trigger, 0);
    chk({tag, "_push"}, stk_push, 0);
    chk({tag, "_wval"}, stk_write_value, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_rvalid"}, result_valid, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_depth"}, depth, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int          base;
    int          cyc;
    logic [3:0]  c;
    rst = 1'b0; op_valid = 1'b0; op_code = '0; op_operand = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;

    do_op(4'd0, 32'hcafe_babe, 1);
    do_op(4'd1, 32'h0, 2);
    chk("push_pop_value", result, 32'hcafe_babe);

    do_op(4'd0, 32'd7, 1);
    do_op(4'd0, 32'd5, 3);
    do_op(4'd3, 32'h0, 2);
    chk("sub_value", result, 32'h0000_0002);
    do_op(4'd7, 32'h0, 1);
    chk("neg_value", result, 32'hffff_fffe);
    do_op(4'd1, 32'h0, 1);

    do_op(4'd0, 32'hdead_beef, 1);
    do_op(4'd0, 32'hb105_f00d, 1);
    do_op(4'd9, 32'h0, 2);
    chk("swap_value", result, 32'hdead_beef);
    do_op(4'd1, 32'h0, 1);
    chk("swap_pop1", result, 32'hdead_beef);
    do_op(4'd1, 32'h0, 3);
    chk("swap_pop2", result, 32'hb105_f00d);

    do_op(4'd0, 32'hffff_ffff, 1);
    do_op(4'd0, 32'h1, 1);
    do_op(4'd2, 32'h0, 1);
    chk("wrap_add", result, 32'h0);
    do_op(4'd1, 32'h0, 1);

    do_op(4'd1, 32'h0, 1);
    chk("underflow_depth", depth, 0);
    do_op(4'd12, 32'h0, 1);

    for (int i = 0; i < 16; i++) do_op(4'd0, $urandom, 1 + (i % 3));
    do_op(4'd0, 32'h1234, 1);
    do_op(4'd8, 32'h0, 1);
    chk("overflow_depth", depth, 16);
    do_op(4'd1, 32'h0, 1);
    do_op(4'd1, 32'h0, 1);

    // Reset while ADD is issuing its second pop.
    do_op(4'd0, 32'd40, 1);
    do_op(4'd0, 32'd2, 1);
    @(negedge clk);
    base = trig_cnt; d_cfg = 3;
    op_valid = 1'b1; op_code = 4'd2; op_operand = '0;
    @(negedge clk);
    op_valid = 1'b0;
    cyc = 0;
    while (!(stk_trigger && (trig_cnt - base) == 1) && cyc < 50) begin
      @(negedge clk); cyc++;
    end
    chk("reach_pop2_issue", stk_trigger, 1);
    #2 rst = 1'b0;
    #1 check_reset_outputs("midreset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midreset_no_rvalid", result_valid, 0);
    end
    rst = 1'b1;
    ref_q.delete();
    hold_res = '0;
    do_op(4'd0, 32'd3, 2);
    do_op(4'd1, 32'h0, 2);
    chk("post_reset_pop", result, 32'd3);

    for (int i = 0; i < 150; i++) begin
      c = 4'($urandom_range(0, 11));
      if (ref_q.size() < 2 && ($urandom % 2) == 0) c = 4'd0;
      do_op(c, $urandom, $urandom_range(1, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
